// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO family.
//   clog2     : ceil(log2(n)) for any positive n, clog2(1) = 0
//   FIFO_STD  : standard read mode (q updates after rd)
//   FIFO_FWFT : first-word-fall-through read mode
package fifo_pkg;

  localparam int unsigned FIFO_STD  = 0;
  localparam int unsigned FIFO_FWFT = 1;

  // Smallest r with 2**r >= n; valid for non-power-of-two n.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned     r;
    longint unsigned v;
    r = 0;
    v = 1;
    while (v < longint'(n)) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_ram_sdp.sv
// Simple dual-port RAM, WIDTH x DEPTH, one write port and one registered
// read port. Storage is never reset; the read register has a synchronous
// clear so the FIFO output starts at zero.
//   i_clk   : clock
//   i_rst   : synchronous active-high clear of the read register
//   i_we    : write enable, i_waddr / i_wdata
//   i_re    : read enable, i_raddr -> o_rdata one cycle later (holds otherwise)
module fifo_ram_sdp #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  (* ramstyle = "M9K" *) logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Write port
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read port
  always_ff @(posedge i_clk) begin
    if (i_rst)     r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fifo_syn_ex.sv
// Single-clock FIFO, any DEPTH >= 2, standard or FWFT read mode, with
// programmable almost flags, 0..DEPTH occupancy and sticky error flags.
//   clk, rst         : clock, synchronous active-high reset
//   wr, data         : write request and data
//   rd               : read request (FWFT: acknowledge of the head word)
//   clr_err          : clears overflow / underflow
//   q                : read data
//   full, empty      : usedw == DEPTH / usedw == 0
//   almost_full      : usedw >= AFULL_TH
//   almost_empty     : usedw <= AEMPTY_TH
//   usedw            : occupancy 0..DEPTH
//   overflow         : sticky, write attempted while full
//   underflow        : sticky, read attempted while empty
module fifo_syn_ex
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned FWFT      = FIFO_STD,
  parameter int unsigned AFULL_TH  = DEPTH - 2,
  parameter int unsigned AEMPTY_TH = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr,
  input  logic                         rd,
  input  logic [WIDTH-1:0]             data,
  input  logic                         clr_err,
  output logic [WIDTH-1:0]             q,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [clog2(DEPTH+1)-1:0]    usedw,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned CW = clog2(DEPTH+1);

  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_usedw;
  logic             r_full, r_empty, r_afull, r_aempty, r_ovf, r_udf;
  logic [CW-1:0]    w_usedw_nxt;
  logic             w_wr_ok, w_rd_ok;
  logic             w_ram_we, w_ram_re;
  logic [WIDTH-1:0] w_ram_rdata;

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign w_wr_ok = wr & ~r_full;
  assign w_rd_ok = rd & ~r_empty;

  // Next occupancy
  always_comb begin
    w_usedw_nxt = r_usedw;
    if (w_wr_ok && !w_rd_ok)      w_usedw_nxt = r_usedw + CW'(1);
    else if (!w_wr_ok && w_rd_ok) w_usedw_nxt = r_usedw - CW'(1);
  end

  // Occupancy, flags derived from next occupancy, sticky errors
  always_ff @(posedge clk) begin
    if (rst) begin
      r_usedw  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      r_usedw  <= w_usedw_nxt;
      r_full   <= (w_usedw_nxt == CW'(DEPTH));
      r_empty  <= (w_usedw_nxt == '0);
      r_afull  <= (w_usedw_nxt >= CW'(AFULL_TH));
      r_aempty <= (w_usedw_nxt <= CW'(AEMPTY_TH));
      // A new error event wins over a simultaneous clear.
      r_ovf    <= (r_ovf & ~clr_err) | (wr & r_full);
      r_udf    <= (r_udf & ~clr_err) | (rd & r_empty);
    end
  end

  // RAM pointers advance only on actual RAM accesses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_ram_we) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_ram_re) r_rd_ptr <= ptr_inc(r_rd_ptr);
    end
  end

  fifo_ram_sdp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_we    (w_ram_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (data),
    .i_re    (w_ram_re),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_ram_rdata)
  );

  if (FWFT == FIFO_FWFT) begin : g_fwft
    // The head word lives in an output stage: either the RAM read register
    // or a bypass register loaded straight from data when the RAM holds
    // nothing behind the head. The RAM therefore holds usedw-1 words.
    logic             w_need_load, w_ram_has, w_fetch, w_byp;
    logic [WIDTH-1:0] r_byp;
    logic             r_sel_byp;

    assign w_need_load = r_empty | w_rd_ok;
    assign w_ram_has   = (r_usedw > CW'(1));
    assign w_fetch     = w_need_load & w_ram_has;
    assign w_byp       = w_need_load & ~w_ram_has & w_wr_ok;
    assign w_ram_we    = w_wr_ok & ~w_byp;
    assign w_ram_re    = w_fetch;

    // Output stage source select; unchanged when draining to empty so q holds
    always_ff @(posedge clk) begin
      if (rst) begin
        r_byp     <= '0;
        r_sel_byp <= 1'b1;
      end else if (w_byp) begin
        r_byp     <= data;
        r_sel_byp <= 1'b1;
      end else if (w_fetch) begin
        r_sel_byp <= 1'b0;
      end
    end

    assign q = r_sel_byp ? r_byp : w_ram_rdata;
  end else begin : g_std
    assign w_ram_we = w_wr_ok;
    assign w_ram_re = w_rd_ok;
    assign q        = w_ram_rdata;
  end

  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;
  assign usedw        = r_usedw;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule

// File: tb/tb_fifo_syn_ex.sv
// Bench for fifo_syn_ex: a standard-mode and an FWFT-mode instance share the
// same stimulus and are compared against a queue-based reference model.
module tb_fifo_syn_ex;

  localparam int D = 6;

  logic       clk = 1'b0;
  logic       rst, wr, rd, clr_err;
  logic [7:0] data;

  logic [7:0] q_s, q_f;
  logic       full_s, empty_s, af_s, ae_s, ovf_s, udf_s;
  logic       full_f, empty_f, af_f, ae_f, ovf_f, udf_f;
  logic [2:0] usedw_s, usedw_f;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [7:0] mq[$];
  logic [7:0] m_qs, m_qf;
  logic       m_ovf, m_udf;

  always #5 clk = ~clk;

  fifo_syn_ex #(.WIDTH(8), .DEPTH(D), .FWFT(0), .AFULL_TH(5), .AEMPTY_TH(1)) u_std (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .data(data), .clr_err(clr_err),
    .q(q_s), .full(full_s), .empty(empty_s), .almost_full(af_s), .almost_empty(ae_s),
    .usedw(usedw_s), .overflow(ovf_s), .underflow(udf_s));

  fifo_syn_ex #(.WIDTH(8), .DEPTH(D), .FWFT(1), .AFULL_TH(5), .AEMPTY_TH(1)) u_fwft (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .data(data), .clr_err(clr_err),
    .q(q_f), .full(full_f), .empty(empty_f), .almost_full(af_f), .almost_empty(ae_f),
    .usedw(usedw_f), .overflow(ovf_f), .underflow(udf_f));

  // Drive one clock of stimulus, advance the model, settle 1 time unit past the edge.
  task automatic cycle(input logic i_wr, input logic i_rd, input logic [7:0] i_d,
                       input logic i_clr, input logic i_rst);
    bit mf, me;
    wr = i_wr; rd = i_rd; data = i_d; clr_err = i_clr; rst = i_rst;
    @(posedge clk);
    if (i_rst) begin
      mq.delete();
      m_qs = 8'h00; m_qf = 8'h00; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      mf = (mq.size() == D);
      me = (mq.size() == 0);
      m_ovf = (m_ovf & ~i_clr) | (i_wr & mf);
      m_udf = (m_udf & ~i_clr) | (i_rd & me);
      if (i_rd && !me) m_qs = mq.pop_front();
      if (i_wr && !mf) mq.push_back(i_d);
      if (mq.size() > 0) m_qf = mq[0];
    end
    #1;
    wr = 1'b0; rd = 1'b0; clr_err = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    cycle(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 5; i++) cycle(0, 0, 8'h00, 0, 0);
    checks++;
    if ({full_s, empty_s, af_s, ae_s, usedw_s, ovf_s, udf_s} !== 9'b0101_000_00) begin
      errors++; $display("FAIL reset_std_status: got %b expected %b",
        {full_s, empty_s, af_s, ae_s, usedw_s, ovf_s, udf_s}, 9'b0101_000_00);
    end
    checks++;
    if ({full_f, empty_f, af_f, ae_f, usedw_f, ovf_f, udf_f} !== 9'b0101_000_00) begin
      errors++; $display("FAIL reset_fwft_status: got %b expected %b",
        {full_f, empty_f, af_f, ae_f, usedw_f, ovf_f, udf_f}, 9'b0101_000_00);
    end
    checks++;
    if (q_s !== 8'h00 || q_f !== 8'h00) begin
      errors++; $display("FAIL reset_q: got std=%h fwft=%h expected 00", q_s, q_f);
    end
  endtask

  task automatic test_std_fill();
    cycle(0, 0, 8'h00, 0, 1);
    for (int k = 0; k < 6; k++) begin
      cycle(1, 0, 8'(8'h11 + k), 0, 0);
      if (k == 0) begin
        checks++;
        if (q_f !== 8'h11) begin
          errors++; $display("FAIL fill_fwft_first: got %h expected 11", q_f);
        end
      end
    end
    checks++;
    if (full_s !== 1'b1 || usedw_s !== 3'd6 || ovf_s !== 1'b0) begin
      errors++; $display("FAIL fill_full: got full=%b usedw=%0d ovf=%b expected 1 6 0",
        full_s, usedw_s, ovf_s);
    end
    cycle(1, 0, 8'hEE, 0, 0);
    cycle(1, 0, 8'hEF, 0, 0);
    checks++;
    if (ovf_s !== 1'b1 || usedw_s !== 3'd6) begin
      errors++; $display("FAIL fill_overflow: got ovf=%b usedw=%0d expected 1 6", ovf_s, usedw_s);
    end
    for (int k = 0; k < 6; k++) begin
      cycle(0, 1, 8'h00, 0, 0);
      checks++;
      if (q_s !== 8'(8'h11 + k)) begin
        errors++; $display("FAIL drain_q[%0d]: got %h expected %h", k, q_s, 8'(8'h11 + k));
      end
    end
    cycle(0, 1, 8'h00, 0, 0);
    checks++;
    if (udf_s !== 1'b1 || q_s !== 8'h16 || q_f !== 8'h16 || empty_s !== 1'b1) begin
      errors++; $display("FAIL drain_underflow: got udf=%b q_std=%h q_fwft=%h empty=%b expected 1 16 16 1",
        udf_s, q_s, q_f, empty_s);
    end
  endtask

  task automatic test_fwft_single();
    cycle(0, 0, 8'h00, 0, 1);
    cycle(1, 0, 8'hA5, 0, 0);
    checks++;
    if (empty_f !== 1'b0 || q_f !== 8'hA5) begin
      errors++; $display("FAIL fwft_fallthrough: got empty=%b q=%h expected 0 a5", empty_f, q_f);
    end
    cycle(0, 1, 8'h00, 0, 0);
    checks++;
    if (empty_f !== 1'b1 || usedw_f !== 3'd0 || q_f !== 8'hA5) begin
      errors++; $display("FAIL fwft_pop: got empty=%b usedw=%0d q=%h expected 1 0 a5",
        empty_f, usedw_f, q_f);
    end
  endtask

  task automatic test_back_to_back();
    cycle(0, 0, 8'h00, 0, 1);
    for (int k = 0; k < 3; k++) cycle(1, 0, 8'(8'h30 + k), 0, 0);
    for (int i = 0; i < 20; i++) begin
      cycle(1, 1, 8'(8'h33 + i), 0, 0);
      checks++;
      if (usedw_s !== 3'd3 || usedw_f !== 3'd3 || q_s !== 8'(8'h30 + i) || q_f !== 8'(8'h31 + i)) begin
        errors++; $display("FAIL stream[%0d]: got usedw=%0d/%0d q=%h/%h expected 3 %h/%h", i,
          usedw_s, usedw_f, q_s, q_f, 8'(8'h30 + i), 8'(8'h31 + i));
      end
    end
    // Remaining words 44,45,46; top up to full.
    for (int k = 0; k < 3; k++) cycle(1, 0, 8'(8'h50 + k), 0, 0);
    // At full the read is accepted and the write rejected.
    cycle(1, 1, 8'h60, 0, 0);
    checks++;
    if (usedw_s !== 3'd5 || ovf_s !== 1'b1 || q_s !== 8'h44 || q_f !== 8'h45 || full_f !== 1'b0) begin
      errors++; $display("FAIL full_wr_rd: got usedw=%0d ovf=%b q=%h/%h full=%b expected 5 1 44/45 0",
        usedw_s, ovf_s, q_s, q_f, full_f);
    end
  endtask

  task automatic test_thresholds();
    cycle(0, 0, 8'h00, 0, 1);
    for (int k = 1; k <= 6; k++) begin
      cycle(1, 0, 8'(k), 0, 0);
      checks++;
      if (ae_s !== (k <= 1) || af_s !== (k >= 5) || ae_f !== (k <= 1) || af_f !== (k >= 5)) begin
        errors++; $display("FAIL thresh[%0d]: got ae=%b af=%b expected ae=%b af=%b", k,
          ae_s, af_s, (k <= 1), (k >= 5));
      end
    end
    cycle(1, 0, 8'hFF, 0, 0);
    cycle(0, 0, 8'h00, 1, 0);
    checks++;
    if (ovf_s !== 1'b0 || ovf_f !== 1'b0) begin
      errors++; $display("FAIL clr_overflow: got %b/%b expected 0", ovf_s, ovf_f);
    end
    cycle(1, 0, 8'hFF, 1, 0);
    checks++;
    if (ovf_s !== 1'b1) begin
      errors++; $display("FAIL set_wins_clr: got %b expected 1", ovf_s);
    end
    for (int k = 0; k < 7; k++) cycle(0, 1, 8'h00, 0, 0);
    checks++;
    if (udf_s !== 1'b1 || udf_f !== 1'b1) begin
      errors++; $display("FAIL underflow_set: got %b/%b expected 1", udf_s, udf_f);
    end
    cycle(0, 0, 8'h00, 1, 0);
    checks++;
    if (udf_s !== 1'b0 || ovf_s !== 1'b0) begin
      errors++; $display("FAIL clr_both: got udf=%b ovf=%b expected 0 0", udf_s, ovf_s);
    end
  endtask

  task automatic test_reset_mid_wrap();
    cycle(0, 0, 8'h00, 0, 1);
    for (int k = 0; k < 4; k++) cycle(1, 0, 8'(8'h70 + k), 0, 0);
    cycle(1, 1, 8'h7F, 0, 1);
    checks++;
    if (usedw_s !== 3'd0 || empty_s !== 1'b1 || empty_f !== 1'b1) begin
      errors++; $display("FAIL mid_reset: got usedw=%0d empty=%b/%b expected 0 1/1",
        usedw_s, empty_s, empty_f);
    end
    for (int k = 0; k < 3 * D; k++) begin
      cycle(1, 0, 8'(8'h80 + k), 0, 0);
      checks++;
      if (q_f !== 8'(8'h80 + k)) begin
        errors++; $display("FAIL wrap_fwft[%0d]: got %h expected %h", k, q_f, 8'(8'h80 + k));
      end
      cycle(0, 1, 8'h00, 0, 0);
      checks++;
      if (q_s !== 8'(8'h80 + k)) begin
        errors++; $display("FAIL wrap_std[%0d]: got %h expected %h", k, q_s, 8'(8'h80 + k));
      end
    end
  endtask

  task automatic test_random();
    logic [8:0] exp_st;
    int         sz;
    cycle(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50), 8'($urandom),
            1'($urandom_range(0, 99) < 5), 1'($urandom_range(0, 199) == 0));
      sz = mq.size();
      exp_st = {sz == D, sz == 0, sz >= 5, sz <= 1, 3'(sz), m_ovf, m_udf};
      checks++;
      if ({full_s, empty_s, af_s, ae_s, usedw_s, ovf_s, udf_s} !== exp_st ||
          {full_f, empty_f, af_f, ae_f, usedw_f, ovf_f, udf_f} !== exp_st) begin
        errors++; $display("FAIL rand_status[%0d]: got std=%b fwft=%b expected %b", i,
          {full_s, empty_s, af_s, ae_s, usedw_s, ovf_s, udf_s},
          {full_f, empty_f, af_f, ae_f, usedw_f, ovf_f, udf_f}, exp_st);
      end
      checks++;
      if (q_s !== m_qs || q_f !== m_qf) begin
        errors++; $display("FAIL rand_q[%0d]: got std=%h fwft=%h expected %h/%h", i,
          q_s, q_f, m_qs, m_qf);
      end
    end
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; clr_err = 1'b0; data = 8'h00;
    m_qs = 8'h00; m_qf = 8'h00; m_ovf = 1'b0; m_udf = 1'b0;
    test_reset();
    test_std_fill();
    test_fwft_single();
    test_back_to_back();
    test_thresholds();
    test_reset_mid_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
